// File: rtl/tetris_pkg.sv
// Shared types, widths and seven-segment helpers for the score display.
package tetris_pkg;

  localparam int unsigned SCORE_W    = 16;
  localparam int unsigned BCD_DIGITS = 5;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
  localparam int unsigned NUM_DIG    = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned SHIFT_CW   = 4;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {CV_IDLE, CV_SHIFT, CV_COMMIT} cv_state_t;

  // Active-low a..g code; seg[0] is segment a.
  function automatic logic [SEG_W-1:0] seg_encode(logic [3:0] d);
    logic [SEG_W-1:0] code;
    case (d)
      4'd0:    code = 7'h40;
      4'd1:    code = 7'h79;
      4'd2:    code = 7'h24;
      4'd3:    code = 7'h30;
      4'd4:    code = 7'h19;
      4'd5:    code = 7'h12;
      4'd6:    code = 7'h02;
      4'd7:    code = 7'h78;
      4'd8:    code = 7'h00;
      4'd9:    code = 7'h10;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // Double-dabble correction: add 3 to every nibble that is 5 or more.
  function automatic logic [BCD_W-1:0] dd_adjust(logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = 4'(b[i*4 +: 4] + 4'd3);
    end
    return r;
  endfunction

endpackage

// File: rtl/tetris_score_display_if.sv
// Score input and display outputs between the game core side and the display block.
interface tetris_score_display_if;
  import tetris_pkg::*;

  logic [SCORE_W-1:0] score;
  logic [SEG_W-1:0]   seg;
  logic               dp;
  logic [NUM_DIG-1:0] an;
  logic               ovf;

  modport master (output score, input seg, dp, an, ovf);
  modport slave  (input score, output seg, dp, an, ovf);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 16 shift cycles, then a one-cycle commit with done high.
module bin2bcd_seq
  import tetris_pkg::*;
(
  input  logic               gm_clk,
  input  logic               gm_rst,
  input  logic               start,
  input  logic [SCORE_W-1:0] bin,
  output logic               done,
  output logic [BCD_W-1:0]   bcd
);

  cv_state_t             state, state_n;
  logic [SHIFT_CW-1:0]   cnt, cnt_n;
  logic [SCORE_W-1:0]    shreg, shreg_n;
  logic [BCD_W-1:0]      acc, acc_n, adj;
  logic                  done_n;

  always_ff @(posedge gm_clk) begin
    if (gm_rst) begin
      state <= CV_IDLE;
      cnt   <= '0;
      shreg <= '0;
      acc   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      shreg <= shreg_n;
      acc   <= acc_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    acc_n   = acc;
    done_n  = 1'b0;
    adj     = dd_adjust(acc);
    case (state)
      CV_IDLE: begin
        if (start) begin
          shreg_n = bin;
          acc_n   = '0;
          cnt_n   = '0;
          state_n = CV_SHIFT;
        end
      end
      CV_SHIFT: begin
        {acc_n, shreg_n} = {adj[BCD_W-2:0], shreg, 1'b0};
        cnt_n = SHIFT_CW'(cnt + 1'b1);
        // done is registered so it is high exactly during COMMIT
        if (cnt == 4'd15) begin
          state_n = CV_COMMIT;
          done_n  = 1'b1;
        end
      end
      CV_COMMIT: state_n = CV_IDLE;
      default:   state_n = CV_IDLE;
    endcase
  end

  assign bcd = acc;

endmodule

// File: rtl/tetris_score_display.sv
// Score to four multiplexed seven-segment digits, saturating above 9999.
module tetris_score_display
  import tetris_pkg::*;
#(
  parameter int unsigned SCAN_DIV      = 100_000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic                   gm_clk,
  input  logic                   gm_rst,
  tetris_score_display_if.slave  bus
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [SCORE_W-1:0]              last;
  logic                            busy;
  logic                            start;
  logic                            done;
  logic [BCD_W-1:0]                bcd;
  logic [NUM_DIG-1:0][3:0]         disp;

  logic [DIV_W-1:0]                div;
  logic [1:0]                      idx, idx_next;
  logic                            wrap;
  logic [NUM_DIG-1:0]              dig_zero, blank;
  logic [NUM_DIG-1:0][SEG_W-1:0]   dig_seg;
  logic [SEG_W-1:0]                seg_next;

  bin2bcd_seq u_conv (
    .gm_clk (gm_clk),
    .gm_rst (gm_rst),
    .start  (start),
    .bin    (bus.score),
    .done   (done),
    .bcd    (bcd)
  );

  // A new conversion may only start once the previous one has committed.
  assign start = !busy && (bus.score != last);

  // Shadow register, busy tracking and saturating commit.
  always_ff @(posedge gm_clk) begin
    if (gm_rst) begin
      last    <= '0;
      busy    <= 1'b0;
      disp    <= '0;
      bus.ovf <= 1'b0;
    end else if (start) begin
      last <= bus.score;
      busy <= 1'b1;
    end else if (done) begin
      busy <= 1'b0;
      if (bcd[19:16] != 4'd0) begin
        disp    <= {NUM_DIG{4'd9}};
        bus.ovf <= 1'b1;
      end else begin
        disp    <= bcd[15:0];
        bus.ovf <= 1'b0;
      end
    end
  end

  // Per-digit code with leading-zero blanking; digit 0 always shows.
  always_comb begin
    for (int k = 0; k < int'(NUM_DIG); k++) dig_zero[k] = (disp[k] == 4'd0);
    blank[0] = 1'b0;
    blank[1] = BLANK_LEADING && (&dig_zero[3:1]);
    blank[2] = BLANK_LEADING && (&dig_zero[3:2]);
    blank[3] = BLANK_LEADING && dig_zero[3];
    for (int k = 0; k < int'(NUM_DIG); k++) begin
      dig_seg[k] = blank[k] ? SEG_BLANK : seg_encode(disp[k]);
    end
  end

  always_comb begin
    idx_next = 2'(idx + 2'd1);
    wrap     = (div == DIV_W'(SCAN_DIV - 1));
    seg_next = dig_seg[idx_next];
  end

  // Digit scan: idx resets to 3 so the first wrap lands on digit 0.
  always_ff @(posedge gm_clk) begin
    if (gm_rst) begin
      div    <= '0;
      idx    <= 2'd3;
      bus.an <= 4'hF;
      bus.seg <= SEG_BLANK;
      bus.dp <= 1'b1;
    end else begin
      bus.dp <= 1'b1;
      if (wrap) begin
        div     <= '0;
        idx     <= idx_next;
        bus.an  <= ~(4'b0001 << idx_next);
        bus.seg <= seg_next;
      end else begin
        div <= DIV_W'(div + 1'b1);
      end
    end
  end

endmodule
